ss_copy_ctrl: RTL and testbench
===============================

// Module: ss_copy_ctrl
// PURPOSE
//  Sequencer/arbiter for the cartridge memory port shared by CPU cart accesses and a save-state copy engine.
//  CPU has absolute priority; engine copies LEN words SRC->DST (e.g. ROM/RAM bank F <-> io buffer bank E) in CPU idle slots.
//  Sits between the mapper decode (cpu_* side) and the MemBus of rom0/rom1.
// PARAMETERS
//  MEM_LAT   2    read latency in clk cycles, oe asserted to mem_dato valid (>=1)
//  WE_CYC    2    cycles a write strobe is held (>=1)
//  LEN_W     19   width of word-count register
// PORTS
//  clk         in   1    system clock
//  rst_n       in   1    asynchronous active-low reset
//  cpu_req     in   1    mapper-decoded cart access in progress (mem_ce)
//  cpu_oe      in   1    CPU read strobe, active high
//  cpu_we_lo   in   1    CPU low-byte write, active high
//  cpu_we_hi   in   1    CPU high-byte write, active high
//  cpu_addr    in   23   CPU word address, pre-mapped
//  cpu_dati    in   16   CPU write data
//  cpu_dato    out  16   read data to mapper (= mem_dato)
//  eng_start   in   1    1-cycle pulse: launch copy
//  eng_src     in   23   source word address
//  eng_dst     in   23   destination word address
//  eng_len     in   LEN_W  words to copy; 0 = no-op
//  eng_busy    out  1    copy in progress
//  eng_done    out  1    1-cycle pulse on completion
//  mem_addr    out  23   memory address
//  mem_dati    out  16   memory write data
//  mem_dato    in   16   memory read data
//  mem_oe      out  1    memory read strobe
//  mem_we_lo   out  1    memory low-byte write
//  mem_we_hi   out  1    memory high-byte write
// BEHAVIOUR
//  Reset: state IDLE, eng_busy=0, eng_done=0, all counters/addr regs 0; mem_* strobes follow cpu_* (none asserted).
//  Mux (combinational): cpu_req=1 -> mem_* driven from cpu_* (strobes gated by cpu_req), zero latency; else from engine.
//  FSM: IDLE -> RD -> WR -> (RD | FIN) -> IDLE.
//   IDLE: eng_start & eng_len!=0 -> latch src/dst/len, eng_busy=1, RD. eng_len==0 -> eng_done pulse next cycle, stay IDLE.
//   RD: mem_addr=src, mem_oe=1 for MEM_LAT cycles; on last cycle capture mem_dato into data reg -> WR.
//   WR: mem_addr=dst, mem_dati=data reg, we_lo=we_hi=1 for WE_CYC cycles -> src++, dst++, len--; len reaches 0 -> FIN else RD.
//   FIN: eng_busy=0, eng_done=1 for one cycle -> IDLE.
//  Preemption: any cycle with cpu_req=1 in RD/WR freezes state, phase counter resets to 0; phase restarts in full when cpu_req drops.
//   A write interrupted mid-strobe is reissued completely (idempotent); captured read data kept only after a full uninterrupted RD.
//  eng_start while busy: ignored. Address increment wraps modulo 2^23.
//  Reset mid-copy: immediate abort, no eng_done.
// CONFIGURATION
//  SS_COPY_SUM_EN defined: adds out port eng_sum[15:0]; cleared on accepted eng_start, += each word at WR completion (mod 2^16); stable after eng_done.
//  Undefined: no eng_sum port, no adder.
// STRUCTURE
//  Shared package: typedef enum {IDLE,RD,WR,FIN} ss_copy_st_t; localparam MEM_AW=23, MEM_DW=16.
//  One sub-module: ss_copy_mux (combinational cpu/engine port select); FSM+counters in top.
// TESTING
//  src=0x000100,dst=0x700000,len=4, memory preloaded 0xA0..0xA3 -> dst holds same, eng_done once, busy 1->0.
//  len=0 start -> eng_done pulse next cycle, eng_busy never rises, no mem strobe.
//  cpu_req pulse 3 cycles during WR of word 1 -> CPU write lands, word 1 rewritten fully, final image correct.
//  cpu_req held 50 cycles mid-RD -> no engine strobes during hold; RD restarts with full MEM_LAT.
//  eng_start while busy -> ignored, original copy completes unchanged.
//  SUM_EN, words 0x8000,0x8001 -> eng_sum=0x0001; rst_n low mid-copy -> busy=0, no done.

Source files
------------

// File: rtl/ss_copy_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ss_copy_ctrl_pkg
// Shared definitions for the cartridge memory port sequencer: bus widths
// and the copy engine state type.
// No ports (package).
// ----------------------------------------------------------------------------
package ss_copy_ctrl_pkg;

   localparam int MEM_AW = 23;
   localparam int MEM_DW = 16;

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      FIN
   } ss_copy_st_t;

endpackage

// File: rtl/ss_copy_mux.sv
// ----------------------------------------------------------------------------
// ss_copy_mux
// Combinational port select for the shared cartridge memory bus. The CPU
// owns the bus whenever cpu_req is high; otherwise the copy engine drives it.
// Ports:
//   cpu_req             CPU cart access in progress (selects the CPU side)
//   cpu_oe/we_lo/we_hi  CPU strobes, gated by cpu_req
//   cpu_addr, cpu_dati  CPU address / write data
//   seq_oe, seq_we      engine read / write strobes (write drives both bytes)
//   seq_addr, seq_dati  engine address / write data
//   mem_*               resulting memory bus
// ----------------------------------------------------------------------------
module ss_copy_mux
   import ss_copy_ctrl_pkg::*;
(
   input  logic              cpu_req,
   input  logic              cpu_oe,
   input  logic              cpu_we_lo,
   input  logic              cpu_we_hi,
   input  logic [MEM_AW-1:0] cpu_addr,
   input  logic [MEM_DW-1:0] cpu_dati,
   input  logic              seq_oe,
   input  logic              seq_we,
   input  logic [MEM_AW-1:0] seq_addr,
   input  logic [MEM_DW-1:0] seq_dati,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [MEM_DW-1:0] mem_dati,
   output logic              mem_oe,
   output logic              mem_we_lo,
   output logic              mem_we_hi
);

   // CPU has absolute priority and sees zero added latency.
   always_comb begin
      if (cpu_req) begin
         mem_addr  = cpu_addr;
         mem_dati  = cpu_dati;
         mem_oe    = cpu_oe;
         mem_we_lo = cpu_we_lo;
         mem_we_hi = cpu_we_hi;
      end else begin
         mem_addr  = seq_addr;
         mem_dati  = seq_dati;
         mem_oe    = seq_oe;
         mem_we_lo = seq_we;
         mem_we_hi = seq_we;
      end
   end

endmodule

// File: rtl/ss_copy_ctrl.sv
// ----------------------------------------------------------------------------
// ss_copy_ctrl
// Sequencer/arbiter for the cartridge memory port shared by CPU accesses and
// a save-state copy engine. The engine copies LEN words SRC->DST using only
// the cycles in which the CPU is not requesting the bus.
// Optional feature macro: SS_COPY_SUM_EN adds eng_sum, a 16-bit running sum
// of the copied words.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_req/oe/we_lo/we_hi, cpu_addr, cpu_dati   CPU side (mapper decoded)
//   cpu_dato              read data back to the mapper (= mem_dato)
//   eng_start             1-cycle launch pulse
//   eng_src/dst/len       copy source, destination and word count
//   eng_busy, eng_done    copy in progress / 1-cycle completion pulse
//   eng_sum               (SS_COPY_SUM_EN only) sum of copied words
//   mem_addr/dati/oe/we_lo/we_hi, mem_dato       memory bus
// ----------------------------------------------------------------------------
module ss_copy_ctrl
   import ss_copy_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int WE_CYC  = 2,
   parameter int LEN_W   = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_oe,
   input  logic              cpu_we_lo,
   input  logic              cpu_we_hi,
   input  logic [MEM_AW-1:0] cpu_addr,
   input  logic [MEM_DW-1:0] cpu_dati,
   output logic [MEM_DW-1:0] cpu_dato,
   input  logic              eng_start,
   input  logic [MEM_AW-1:0] eng_src,
   input  logic [MEM_AW-1:0] eng_dst,
   input  logic [LEN_W-1:0]  eng_len,
   output logic              eng_busy,
   output logic              eng_done,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [MEM_DW-1:0] mem_dati,
   input  logic [MEM_DW-1:0] mem_dato,
   output logic              mem_oe,
   output logic              mem_we_lo,
   output logic              mem_we_hi
`ifdef SS_COPY_SUM_EN
   ,
   output logic [MEM_DW-1:0] eng_sum
`endif
);

   localparam int PH_MAX = (MEM_LAT > WE_CYC) ? MEM_LAT : WE_CYC;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
   localparam logic [PH_W-1:0] RD_LAST = PH_W'(MEM_LAT - 1);
   localparam logic [PH_W-1:0] WR_LAST = PH_W'(WE_CYC - 1);

   ss_copy_st_t       state;
   ss_copy_st_t       state_nx;
   logic [PH_W-1:0]   phase;
   logic [PH_W-1:0]   phase_nx;
   logic [MEM_AW-1:0] src;
   logic [MEM_AW-1:0] dst;
   logic [LEN_W-1:0]  len;
   logic [MEM_DW-1:0] data;
   logic              zero_done;
   logic              load;
   logic              zero_start;
   logic              cap;
   logic              adv;
   logic              seq_oe;
   logic              seq_we;
   logic [MEM_AW-1:0] seq_addr;

   assign cpu_dato = mem_dato;

   // State and phase counter register. Phase counts consecutive cycles the
   // engine has actually owned the bus within the current RD or WR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         phase <= '0;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
      end
   end

   // Next state, datapath controls and engine-side bus requests. Any CPU
   // cycle during RD/WR drops the phase back to 0, so an interrupted read is
   // never captured and an interrupted write is reissued in full.
   always_comb begin
      state_nx   = state;
      phase_nx   = phase;
      load       = 1'b0;
      zero_start = 1'b0;
      cap        = 1'b0;
      adv        = 1'b0;
      seq_oe     = 1'b0;
      seq_we     = 1'b0;
      seq_addr   = src;
      eng_busy   = 1'b0;
      eng_done   = zero_done;
      case (state)
         IDLE: begin
            if (eng_start) begin
               if (eng_len != '0) begin
                  load     = 1'b1;
                  phase_nx = '0;
                  state_nx = RD;
               end else begin
                  zero_start = 1'b1;
               end
            end
         end
         RD: begin
            eng_busy = 1'b1;
            seq_oe   = 1'b1;
            seq_addr = src;
            if (cpu_req) begin
               phase_nx = '0;
            end else if (phase == RD_LAST) begin
               cap      = 1'b1;
               phase_nx = '0;
               state_nx = WR;
            end else begin
               phase_nx = phase + 1'b1;
            end
         end
         WR: begin
            eng_busy = 1'b1;
            seq_we   = 1'b1;
            seq_addr = dst;
            if (cpu_req) begin
               phase_nx = '0;
            end else if (phase == WR_LAST) begin
               adv      = 1'b1;
               phase_nx = '0;
               state_nx = (len == LEN_W'(1)) ? FIN : RD;
            end else begin
               phase_nx = phase + 1'b1;
            end
         end
         FIN: begin
            eng_done = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Copy datapath: address/count registers, the word in flight, and the
   // one-cycle-late done pulse for a zero-length request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src       <= '0;
         dst       <= '0;
         len       <= '0;
         data      <= '0;
         zero_done <= 1'b0;
      end else begin
         zero_done <= zero_start;
         if (load) begin
            src <= eng_src;
            dst <= eng_dst;
            len <= eng_len;
         end
         if (cap) begin
            data <= mem_dato;
         end
         if (adv) begin
            src <= src + 1'b1;
            dst <= dst + 1'b1;
            len <= len - 1'b1;
         end
      end
   end

`ifdef SS_COPY_SUM_EN
   logic [MEM_DW-1:0] sum_q;

   assign eng_sum = sum_q;

   // Running checksum of completed word writes, restarted by each accepted
   // launch (a zero-length launch leaves it at 0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else if (load || zero_start) begin
         sum_q <= '0;
      end else if (adv) begin
         sum_q <= sum_q + data;
      end
   end
`endif

   ss_copy_mux u_mux (
      .cpu_req   (cpu_req),
      .cpu_oe    (cpu_oe),
      .cpu_we_lo (cpu_we_lo),
      .cpu_we_hi (cpu_we_hi),
      .cpu_addr  (cpu_addr),
      .cpu_dati  (cpu_dati),
      .seq_oe    (seq_oe),
      .seq_we    (seq_we),
      .seq_addr  (seq_addr),
      .seq_dati  (data),
      .mem_addr  (mem_addr),
      .mem_dati  (mem_dati),
      .mem_oe    (mem_oe),
      .mem_we_lo (mem_we_lo),
      .mem_we_hi (mem_we_hi)
   );

endmodule

// File: tb/tb_ss_copy_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ss_copy_ctrl
// Bench for ss_copy_ctrl: a pipelined memory model on the bus, a reference
// model that turns each launch into the list of word writes it must produce,
// and a monitor that retires those writes and completions as they appear.
// Build with SS_COPY_SUM_EN defined to also exercise eng_sum.
// ----------------------------------------------------------------------------
module tb_ss_copy_ctrl;

   localparam int MEM_LAT = 2;
   localparam int WE_CYC  = 2;
   localparam int LEN_W   = 19;

   typedef struct packed {
      logic [22:0] addr;
      logic [15:0] data;
   } wr_t;

   typedef struct packed {
      logic [18:0] len;
      logic [15:0] sum;
   } comp_t;

   logic        clk;
   logic        rst_n;
   logic        cpu_req;
   logic        cpu_oe;
   logic        cpu_we_lo;
   logic        cpu_we_hi;
   logic [22:0] cpu_addr;
   logic [15:0] cpu_dati;
   logic [15:0] cpu_dato;
   logic        eng_start;
   logic [22:0] eng_src;
   logic [22:0] eng_dst;
   logic [18:0] eng_len;
   logic        eng_busy;
   logic        eng_done;
   logic [22:0] mem_addr;
   logic [15:0] mem_dati;
   logic [15:0] mem_dato;
   logic        mem_oe;
   logic        mem_we_lo;
   logic        mem_we_hi;
`ifdef SS_COPY_SUM_EN
   logic [15:0] eng_sum;
`endif

   logic [15:0] mem [logic [22:0]];
   logic [15:0] rd_q;
   logic [22:0] oe_addr;
   int          oe_run;

   wr_t         exp_wr[$];
   comp_t       comp_q[$];
   int          total;
   int          passed;
   int          done_seen;
   int          done_expected;
   int          wr_run;
   logic [22:0] wr_addr;
   logic [15:0] wr_dat;
   wr_t         w_mon;
   comp_t       c_mon;

   ss_copy_ctrl #(
      .MEM_LAT (MEM_LAT),
      .WE_CYC  (WE_CYC),
      .LEN_W   (LEN_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_req   (cpu_req),
      .cpu_oe    (cpu_oe),
      .cpu_we_lo (cpu_we_lo),
      .cpu_we_hi (cpu_we_hi),
      .cpu_addr  (cpu_addr),
      .cpu_dati  (cpu_dati),
      .cpu_dato  (cpu_dato),
      .eng_start (eng_start),
      .eng_src   (eng_src),
      .eng_dst   (eng_dst),
      .eng_len   (eng_len),
      .eng_busy  (eng_busy),
      .eng_done  (eng_done),
      .mem_addr  (mem_addr),
      .mem_dati  (mem_dati),
      .mem_dato  (mem_dato),
      .mem_oe    (mem_oe),
      .mem_we_lo (mem_we_lo),
      .mem_we_hi (mem_we_hi)
`ifdef SS_COPY_SUM_EN
      ,
      .eng_sum   (eng_sum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] mem_read(input logic [22:0] a);
      if (mem.exists(a)) return mem[a];
      return 16'h0000;
   endfunction

   // Memory model: read data is only valid once oe has been held on the same
   // address for MEM_LAT consecutive cycles; before that it returns garbage.
   assign mem_dato = (mem_oe && oe_run >= MEM_LAT - 1 && mem_addr == oe_addr) ? rd_q : 16'hDEAD;

   always @(posedge clk) begin
      logic [15:0] wtmp;
      if (mem_oe) begin
         rd_q    <= mem_read(mem_addr);
         oe_run  <= (oe_run > 0 && mem_addr == oe_addr) ? oe_run + 1 : 1;
         oe_addr <= mem_addr;
      end else begin
         oe_run <= 0;
      end
      if (mem_we_lo || mem_we_hi) begin
         wtmp = mem_read(mem_addr);
         if (mem_we_lo) wtmp[7:0] = mem_dati[7:0];
         if (mem_we_hi) wtmp[15:8] = mem_dati[15:8];
         mem[mem_addr] = wtmp;
      end
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: retires a complete engine write (WE_CYC uninterrupted cycles)
   // against the next expected write and each done pulse against the next
   // expected completion.
   always @(negedge clk) begin
      if (!rst_n) begin
         wr_run = 0;
      end else begin
         if (cpu_req) begin
            check_output("mux_cpu_path", {mem_addr, mem_dati, mem_oe, mem_we_lo, mem_we_hi},
                         {cpu_addr, cpu_dati, cpu_oe, cpu_we_lo, cpu_we_hi});
         end
         if (!cpu_req && mem_we_lo && mem_we_hi) begin
            if (wr_run > 0 && mem_addr == wr_addr && mem_dati == wr_dat) wr_run++;
            else wr_run = 1;
            wr_addr = mem_addr;
            wr_dat  = mem_dati;
            if (wr_run == WE_CYC) begin
               wr_run = 0;
               check_output("eng_wr_pending", exp_wr.size() > 0, 1);
               if (exp_wr.size() > 0) begin
                  w_mon = exp_wr.pop_front();
                  check_output("eng_wr_addr", mem_addr, w_mon.addr);
                  check_output("eng_wr_data", mem_dati, w_mon.data);
               end
            end
         end else begin
            wr_run = 0;
         end
         if (eng_done) begin
            done_seen++;
            check_output("done_pending", comp_q.size() > 0, 1);
            if (comp_q.size() > 0) begin
               c_mon = comp_q.pop_front();
               check_output("busy_at_done", eng_busy, 0);
               check_output("writes_left_at_done", exp_wr.size(), 0);
`ifdef SS_COPY_SUM_EN
               check_output("sum_at_done", eng_sum, c_mon.sum);
`endif
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_idle();
      cpu_req   = 1'b0;
      cpu_oe    = 1'b0;
      cpu_we_lo = 1'b0;
      cpu_we_hi = 1'b0;
      cpu_addr  = '0;
      cpu_dati  = '0;
   endtask

   // Reference model: a copy is the list of writes dst+i <= mem[src+i]
   // (addresses modulo 2^23) plus one completion carrying the word sum.
   task automatic apply_stimulus(input logic [22:0] src, input logic [22:0] dst, input logic [18:0] len);
      logic [15:0] sum;
      wr_t         w;
      comp_t       c;
      sum = 16'h0000;
      for (int i = 0; i < int'(len); i++) begin
         w.addr = dst + 23'(i);
         w.data = mem_read(src + 23'(i));
         sum    = sum + w.data;
         exp_wr.push_back(w);
      end
      c.len = len;
      c.sum = sum;
      comp_q.push_back(c);
      done_expected++;
      eng_src   = src;
      eng_dst   = dst;
      eng_len   = len;
      eng_start = 1'b1;
      tick();
      eng_start = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input bit disturb);
      int d0;
      int n;
      d0 = done_seen;
      n  = 0;
      while (done_seen == d0 && n < budget) begin
         if (disturb && $urandom_range(0, 3) == 0) begin
            cpu_req = 1'b1;
            if ($urandom_range(0, 1) == 0) begin
               cpu_oe    = 1'b1;
               cpu_we_lo = 1'b0;
               cpu_we_hi = 1'b0;
               cpu_addr  = 23'h040000 + 23'($urandom_range(0, 255));
            end else begin
               cpu_oe    = 1'b0;
               cpu_we_lo = 1'($urandom_range(0, 1));
               cpu_we_hi = ~cpu_we_lo | 1'($urandom_range(0, 1));
               cpu_addr  = 23'h060000 + 23'($urandom_range(0, 255));
               cpu_dati  = 16'($urandom);
            end
         end else begin
            cpu_idle();
         end
         tick();
         n++;
      end
      cpu_idle();
      check_output("done_within_budget", done_seen != d0, 1);
   endtask

   initial begin
      int          n;
      int          k;
      int          bad;
      int          d0;
      logic [22:0] s;
      logic [22:0] d;
      logic [18:0] l;

      total = 0; passed = 0; done_seen = 0; done_expected = 0; wr_run = 0;
      oe_run = 0; rd_q = '0; oe_addr = '0;
      rst_n = 1'b0;
      cpu_idle();
      eng_start = 1'b0; eng_src = '0; eng_dst = '0; eng_len = '0;
      repeat (3) tick();

      check_output("reset_busy", eng_busy, 0);
      check_output("reset_done", eng_done, 0);
      check_output("reset_strobes", {mem_oe, mem_we_lo, mem_we_hi}, 3'b000);
`ifdef SS_COPY_SUM_EN
      check_output("reset_sum", eng_sum, 16'h0000);
`endif
      rst_n = 1'b1;
      tick();

      // Basic four-word copy.
      for (int i = 0; i < 4; i++) mem[23'h000100 + 23'(i)] = 16'h00A0 + 16'(i);
      apply_stimulus(23'h000100, 23'h700000, 19'd4);
      check_output("busy_after_start", eng_busy, 1);
      run_until_done(200, 1'b0);
      for (int i = 0; i < 4; i++)
         check_output("basic_image", mem_read(23'h700000 + 23'(i)), 16'h00A0 + 16'(i));
      tick();
      check_output("busy_after_done", eng_busy, 0);

      // Zero-length launch: done one cycle later, never busy, no strobes.
      d0 = done_seen;
      apply_stimulus(23'h000123, 23'h000456, 19'd0);
      check_output("len0_done", eng_done, 1);
      check_output("len0_busy", eng_busy, 0);
      check_output("len0_strobes", {mem_oe, mem_we_lo, mem_we_hi}, 3'b000);
      tick();
      check_output("len0_done_width", eng_done, 0);
      check_output("len0_busy_after", eng_busy, 0);
      check_output("len0_done_count", done_seen - d0, 1);

      // CPU write burst while the engine is writing word 1.
      for (int i = 0; i < 4; i++) mem[23'h000200 + 23'(i)] = 16'h00B0 + 16'(i);
      apply_stimulus(23'h000200, 23'h700100, 19'd4);
      n = 0;
      while (!(mem_we_lo && !cpu_req && mem_addr == 23'h700101) && n < 200) begin
         tick();
         n++;
      end
      check_output("wr1_reached", n < 200, 1);
      cpu_req = 1'b1; cpu_we_lo = 1'b1; cpu_we_hi = 1'b1;
      cpu_addr = 23'h050000; cpu_dati = 16'h1234;
      repeat (3) tick();
      cpu_idle();
      run_until_done(200, 1'b0);
      check_output("cpu_write_landed", mem_read(23'h050000), 16'h1234);
      for (int i = 0; i < 4; i++)
         check_output("preempt_wr_image", mem_read(23'h700100 + 23'(i)), 16'h00B0 + 16'(i));

      // CPU holds the bus for 50 cycles during a read.
      for (int i = 0; i < 3; i++) mem[23'h000300 + 23'(i)] = 16'h00C0 + 16'(i);
      apply_stimulus(23'h000300, 23'h700200, 19'd3);
      n = 0;
      while (!(mem_oe && !cpu_req && eng_busy) && n < 50) begin
         tick();
         n++;
      end
      check_output("rd_reached", n < 50, 1);
      cpu_req = 1'b1;
      bad = 0;
      repeat (50) begin
         tick();
         if (mem_oe || mem_we_lo || mem_we_hi) bad++;
      end
      check_output("hold_no_strobes", bad, 0);
      check_output("hold_busy_frozen", eng_busy, 1);
      cpu_idle();
      #1;
      n = 0;
      k = 0;
      while (!mem_we_lo && k < 20) begin
         if (mem_oe) n++;
         tick();
         k++;
      end
      check_output("rd_restart_len", n, MEM_LAT);
      run_until_done(200, 1'b0);

      // A second launch while busy must be ignored.
      for (int i = 0; i < 6; i++) mem[23'h000800 + 23'(i)] = 16'($urandom);
      apply_stimulus(23'h000800, 23'h700300, 19'd6);
      repeat (3) tick();
      eng_src = 23'h000900; eng_dst = 23'h600000; eng_len = 19'd9;
      eng_start = 1'b1;
      tick();
      eng_start = 1'b0;
      run_until_done(300, 1'b0);
      repeat (30) tick();
      check_output("ignored_start_no_write", mem_read(23'h600000), 16'h0000);
      check_output("ignored_start_done_count", done_seen, done_expected);

      // Source address wrap at the top of the address space.
      mem[23'h7FFFFE] = 16'h1111; mem[23'h7FFFFF] = 16'h2222;
      mem[23'h000000] = 16'h3333; mem[23'h000001] = 16'h4444;
      apply_stimulus(23'h7FFFFE, 23'h300000, 19'd4);
      run_until_done(200, 1'b0);
      check_output("wrap_word2", mem_read(23'h300002), 16'h3333);

      // Randomised copies with random CPU traffic stealing cycles.
      for (int r = 0; r < 6; r++) begin
         s = 23'h100000 + 23'($urandom_range(0, 255) * 16);
         d = 23'h200000 + 23'(r * 256);
         l = 19'($urandom_range(1, 8));
         for (int i = 0; i < int'(l); i++) mem[s + 23'(i)] = 16'($urandom);
         apply_stimulus(s, d, l);
         run_until_done(1000, 1'b1);
         tick();
      end

`ifdef SS_COPY_SUM_EN
      // Checksum wraps modulo 2^16.
      mem[23'h400000] = 16'h8000; mem[23'h400001] = 16'h8001;
      apply_stimulus(23'h400000, 23'h410000, 19'd2);
      run_until_done(200, 1'b0);
      check_output("sum_wrap", eng_sum, 16'h0001);
`endif

      // Reset in the middle of a copy aborts it without a done pulse.
      for (int i = 0; i < 8; i++) mem[23'h001000 + 23'(i)] = 16'($urandom);
      apply_stimulus(23'h001000, 23'h710000, 19'd8);
      repeat (7) tick();
      rst_n = 1'b0;
      exp_wr.delete();
      comp_q.delete();
      done_expected--;
      #1;
      check_output("abort_busy", eng_busy, 0);
      check_output("abort_done", eng_done, 0);
      check_output("abort_strobes", {mem_oe, mem_we_lo, mem_we_hi}, 3'b000);
`ifdef SS_COPY_SUM_EN
      check_output("abort_sum", eng_sum, 16'h0000);
`endif
      repeat (3) tick();
      rst_n = 1'b1;
      d0 = done_seen;
      repeat (30) tick();
      check_output("abort_no_done", done_seen, d0);
      check_output("abort_idle_busy", eng_busy, 0);

      check_output("final_writes_left", exp_wr.size(), 0);
      check_output("final_comps_left", comp_q.size(), 0);
      check_output("final_done_count", done_seen, done_expected);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
